// File: rtl/rv32e_data_bus_pkg.sv
// Shared memory map and UART state encoding for the rv32e data-memory responder.
// The CPU-side linker script and tests take their region bases from here.
package rv32e_data_bus_pkg;

   localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
   localparam logic [31:0] GPIO_ADDR   = 32'h8000_0000;
   localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0004;
   localparam logic [31:0] UART_ADDR   = 32'h8000_0008;
   localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   // Word accesses only: the byte offset never takes part in decode.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & PERIPH_MASK;
   endfunction

endpackage

// File: rtl/rv32e_uart_tx.sv
// 8N1 serial transmitter; a start pulse while idle latches one byte, starts while busy are dropped.
module rv32e_uart_tx
   import rv32e_data_bus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_e   state_r;
   logic [CW-1:0] baud_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          bit_end_s;

   assign bit_end_s = (baud_r == CW'(CLKS_PER_BIT - 1));
   assign busy      = (state_r != UART_IDLE);
   assign tx        = tx_r;

   // Frame sequencer: line level is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= UART_IDLE;
         baud_r    <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         tx_r      <= 1'b1;
      end else begin
         case (state_r)
            UART_IDLE: begin
               baud_r    <= '0;
               bit_idx_r <= 3'd0;
               if (start) begin
                  shift_r <= data;
                  tx_r    <= 1'b0;
                  state_r <= UART_START;
               end else begin
                  tx_r    <= 1'b1;
               end
            end
            UART_START: begin
               if (bit_end_s) begin
                  baud_r    <= '0;
                  bit_idx_r <= 3'd0;
                  tx_r      <= shift_r[0];
                  state_r   <= UART_DATA;
               end else begin
                  baud_r    <= baud_r + CW'(1);
               end
            end
            UART_DATA: begin
               if (bit_end_s) begin
                  baud_r <= '0;
                  if (bit_idx_r == 3'd7) begin
                     tx_r    <= 1'b1;
                     state_r <= UART_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     shift_r   <= shift_r >> 1;
                     tx_r      <= shift_r[1];
                  end
               end else begin
                  baud_r <= baud_r + CW'(1);
               end
            end
            UART_STOP: begin
               tx_r <= 1'b1;
               if (bit_end_s) begin
                  baud_r  <= '0;
                  state_r <= UART_IDLE;
               end else begin
                  baud_r  <= baud_r + CW'(1);
               end
            end
            default: begin
               baud_r  <= '0;
               tx_r    <= 1'b1;
               state_r <= UART_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/rv32e_data_bus.sv
// Data-memory responder for rv32e_cpu: word RAM, GPIO, cycle counter and UART TX.
// Reads are combinational so the CPU sees data in the same cycle it drives the address.
module rv32e_data_bus
   import rv32e_data_bus_pkg::*;
#(
   parameter int RAM_WORDS    = 1024,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr_bus,
   input  logic [31:0] mem_write_data_bus,
   input  logic        mem_write_signal,
   output logic [31:0] mem_read_data_bus,
   output logic [7:0]  gpio_out,
   output logic        uart_tx
);

   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0]   ram_r [RAM_WORDS];
   logic [31:0]   word_addr_s;
   logic [31:0]   ram_off_s;
   logic [AW-1:0] ram_idx_s;
   logic          sel_ram_s;
   logic          sel_gpio_s;
   logic          sel_cycle_s;
   logic          sel_uart_s;
   logic [7:0]    gpio_r;
   logic [31:0]   cycle_r;
   logic          uart_busy_s;
   logic          uart_start_s;

   assign word_addr_s  = word_align(mem_addr_bus);
   assign ram_off_s    = word_addr_s - RAM_BASE;
   assign ram_idx_s    = mem_addr_bus[AW+1:2];
   assign sel_ram_s    = ((ram_off_s >> (AW + 2)) == 32'd0);
   assign sel_gpio_s   = (word_addr_s == GPIO_ADDR);
   assign sel_cycle_s  = (word_addr_s == CYCLE_ADDR);
   assign sel_uart_s   = (word_addr_s == UART_ADDR);
   assign uart_start_s = mem_write_signal && sel_uart_s;
   assign gpio_out     = gpio_r;

   // RAM has no reset so its contents survive a CPU reset.
   always_ff @(posedge clk) begin
      if (mem_write_signal && sel_ram_s) begin
         ram_r[ram_idx_s] <= mem_write_data_bus;
      end
   end

   // GPIO register and free-running cycle counter; a write to CYCLE beats the increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gpio_r  <= 8'd0;
         cycle_r <= 32'd0;
      end else begin
         if (mem_write_signal && sel_gpio_s) begin
            gpio_r <= mem_write_data_bus[7:0];
         end else begin
            gpio_r <= gpio_r;
         end
         if (mem_write_signal && sel_cycle_s) begin
            cycle_r <= mem_write_data_bus;
         end else begin
            cycle_r <= cycle_r + 32'd1;
         end
      end
   end

   // Zero-latency read mux; unmapped addresses read as zero.
   always_comb begin
      mem_read_data_bus = 32'd0;
      if (sel_ram_s) begin
         mem_read_data_bus = ram_r[ram_idx_s];
      end else if (sel_gpio_s) begin
         mem_read_data_bus = {24'd0, gpio_r};
      end else if (sel_cycle_s) begin
         mem_read_data_bus = cycle_r;
      end else if (sel_uart_s) begin
         mem_read_data_bus = {31'd0, uart_busy_s};
      end else begin
         mem_read_data_bus = 32'd0;
      end
   end

   rv32e_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .start (uart_start_s),
      .data  (mem_write_data_bus[7:0]),
      .busy  (uart_busy_s),
      .tx    (uart_tx)
   );

endmodule

// File: tb/tb_rv32e_data_bus.sv
// Scoreboard bench for rv32e_data_bus: a behavioural model predicts reads, the serial line and GPIO.
module tb_rv32e_data_bus;

   localparam int RAM_WORDS = 64;
   localparam int CPB       = 4;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr_bus;
   logic [31:0] mem_write_data_bus;
   logic        mem_write_signal;
   logic [31:0] mem_read_data_bus;
   logic [7:0]  gpio_out;
   logic        uart_tx;

   rv32e_data_bus #(
      .RAM_WORDS    (RAM_WORDS),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_addr_bus       (mem_addr_bus),
      .mem_write_data_bus (mem_write_data_bus),
      .mem_write_signal   (mem_write_signal),
      .mem_read_data_bus  (mem_read_data_bus),
      .gpio_out           (gpio_out),
      .uart_tx            (uart_tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] exp;
   } rd_item_t;

   typedef struct {
      logic       tx;
      logic [7:0] gpio;
   } ln_item_t;

   rd_item_t rd_q[$];
   ln_item_t ln_q[$];
   rd_item_t rd_it;
   ln_item_t ln_it;
   logic     rd_chk = 1'b0;
   logic     ln_chk = 1'b0;
   int       checks = 0;
   int       errors = 0;

   // Reference model: state as it stands after edge number n.
   logic [31:0] ram_m [RAM_WORDS];
   logic [7:0]  gpio_m;
   logic [31:0] cyc_m;
   int          n        = 0;
   int          frame_k  = -1;
   logic [7:0]  frame_b;
   bit          model_ok = 1'b0;

   function automatic bit busy_m();
      return (frame_k >= 0) && (n >= frame_k) && (n < frame_k + 10 * CPB);
   endfunction

   function automatic logic exp_tx();
      int p;
      logic [7:0] b;
      if (!busy_m()) return 1'b1;
      p = (n - frame_k) / CPB;
      b = frame_b;
      if (p == 0) return 1'b0;
      if (p <= 8) return b[p-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      logic [31:0] wa;
      wa = addr & 32'hFFFF_FFFC;
      if (wa < RAM_WORDS * 4) return ram_m[int'(wa >> 2)];
      if (wa == 32'h8000_0000) return {24'd0, gpio_m};
      if (wa == 32'h8000_0004) return cyc_m;
      if (wa == 32'h8000_0008) return {31'd0, busy_m()};
      return 32'd0;
   endfunction

   // One bus cycle: queue expectations for this cycle, then apply the edge to the model.
   task automatic bus(input bit rst_a, input bit wr, input bit rd,
                      input logic [31:0] addr, input logic [31:0] wd, input string nm);
      logic [31:0] wa;
      reset              = ~rst_a;
      mem_write_signal   = wr;
      mem_addr_bus       = addr;
      mem_write_data_bus = wd;
      if (model_ok && rd) rd_q.push_back('{nm, addr, model_read(addr)});
      rd_chk = model_ok && rd;
      if (model_ok) ln_q.push_back('{exp_tx(), gpio_m});
      ln_chk = model_ok;
      @(posedge clk);
      wa = addr & 32'hFFFF_FFFC;
      if (rst_a) begin
         gpio_m   = 8'd0;
         cyc_m    = 32'd0;
         frame_k  = -1;
         model_ok = 1'b1;
      end else begin
         cyc_m = cyc_m + 32'd1;
         if (wr) begin
            if (wa < RAM_WORDS * 4) ram_m[int'(wa >> 2)] = wd;
            else if (wa == 32'h8000_0000) gpio_m = wd[7:0];
            else if (wa == 32'h8000_0004) cyc_m = wd;
            else if (wa == 32'h8000_0008 && !busy_m()) begin
               frame_k = n + 1;
               frame_b = wd[7:0];
            end
         end
      end
      n = n + 1;
      #1;
   endtask

   // Monitor: pops one expectation per presented output and compares.
   always @(negedge clk) begin
      if (rd_chk) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read_queue_underflow got=%h required=entry", mem_read_data_bus);
         end else begin
            rd_it = rd_q.pop_front();
            if (mem_read_data_bus !== rd_it.exp) begin
               errors++;
               $display("FAIL %s addr=%h got=%h required=%h t=%0t",
                        rd_it.name, rd_it.addr, mem_read_data_bus, rd_it.exp, $time);
            end
         end
      end
      if (ln_chk) begin
         if (ln_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL line_queue_underflow tx=%b gpio=%h", uart_tx, gpio_out);
         end else begin
            ln_it = ln_q.pop_front();
            checks += 2;
            if (uart_tx !== ln_it.tx) begin
               errors++;
               $display("FAIL uart_tx got=%b required=%b t=%0t", uart_tx, ln_it.tx, $time);
            end
            if (gpio_out !== ln_it.gpio) begin
               errors++;
               $display("FAIL gpio_out got=%h required=%h t=%0t", gpio_out, ln_it.gpio, $time);
            end
         end
      end
   end

   localparam logic [31:0] GPIO = 32'h8000_0000;
   localparam logic [31:0] CYC  = 32'h8000_0004;
   localparam logic [31:0] UART = 32'h8000_0008;

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int op;

      // Reset state
      bus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, "pre_reset");
      bus(1'b1, 1'b0, 1'b1, GPIO, 32'd0, "reset_gpio");
      bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "reset_cycle");
      bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "reset_busy");
      for (int i = 0; i < 4; i++) bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "cycle_count");

      // RAM, including ignored byte offset
      bus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, "ram_wr0");
      bus(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h1234_5678, "ram_wr1");
      bus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd0, "ram_rd0");
      bus(1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'd0, "ram_rd1");
      bus(1'b0, 1'b0, 1'b1, 32'h0000_0012, 32'd0, "ram_rd_unaligned");

      // GPIO and reset clearing it
      bus(1'b0, 1'b1, 1'b1, GPIO, 32'hFFFF_FFA5, "gpio_wr");
      bus(1'b0, 1'b0, 1'b1, GPIO, 32'd0, "gpio_rd");
      bus(1'b1, 1'b0, 1'b0, GPIO, 32'd0, "gpio_reset");
      bus(1'b0, 1'b0, 1'b1, GPIO, 32'd0, "gpio_after_reset");

      // CYCLE wrap and write-over-increment
      bus(1'b0, 1'b1, 1'b1, CYC, 32'hFFFF_FFFE, "cycle_wr");
      bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "cycle_ffff");
      bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "cycle_wrap");
      bus(1'b0, 1'b1, 1'b1, CYC, 32'h0000_1000, "cycle_wr2");
      bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "cycle_written");

      // UART frame of 0x55, second write mid-frame dropped
      bus(1'b0, 1'b1, 1'b1, UART, 32'h0000_0055, "uart_send55");
      for (int i = 0; i < 44; i++) begin
         if (i == 10) bus(1'b0, 1'b1, 1'b1, UART, 32'h0000_0041, "uart_drop41");
         else bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "uart_busy55");
      end

      // Back-to-back: write held across the end of the frame
      bus(1'b0, 1'b1, 1'b0, UART, 32'h0000_00C3, "uart_sendC3");
      for (int i = 0; i < 39; i++) bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "uart_busyC3");
      bus(1'b0, 1'b1, 1'b1, UART, 32'h0000_0099, "uart_stop_edge_wr");
      for (int i = 0; i < 6; i++) bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "uart_idle");

      // Reset mid-DATA
      bus(1'b0, 1'b1, 1'b0, UART, 32'h0000_00F0, "uart_sendF0");
      for (int i = 0; i < 15; i++) bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "uart_busyF0");
      bus(1'b1, 1'b0, 1'b0, UART, 32'd0, "uart_reset");
      for (int i = 0; i < 3; i++) bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "uart_after_reset");

      // Unmapped access leaves everything else alone
      bus(1'b0, 1'b1, 1'b0, GPIO, 32'h0000_003C, "gpio_set");
      bus(1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'hCAFE_F00D, "unmapped_wr");
      bus(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0, "unmapped_rd");
      bus(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, "past_ram_wr");
      bus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd0, "ram_kept");
      bus(1'b0, 1'b0, 1'b1, GPIO, 32'd0, "gpio_kept");
      bus(1'b0, 1'b0, 1'b1, CYC, 32'd0, "cycle_kept");

      // Prefill RAM, then randomized traffic
      for (int i = 0; i < RAM_WORDS; i++)
         bus(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, "ram_fill");
      for (int i = 0; i < 600; i++) begin
         op = $urandom_range(0, 9);
         d  = $urandom;
         a  = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
         if ($urandom_range(0, 127) == 0) bus(1'b1, 1'b0, 1'b1, GPIO, d, "rnd_reset");
         else case (op)
            0:       bus(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, d, "rnd_ram_wr");
            1:       bus(1'b0, 1'b0, 1'b1, a, d, "rnd_ram_rd");
            2:       bus(1'b0, 1'($urandom_range(0, 1)), 1'b1, GPIO | 32'($urandom_range(0, 3)), d, "rnd_gpio");
            3:       bus(1'b0, 1'b0, 1'b1, CYC, d, "rnd_cycle_rd");
            4:       bus(1'b0, 1'b1, 1'b1, CYC, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : d, "rnd_cycle_wr");
            5:       bus(1'b0, 1'b1, 1'b1, UART, d, "rnd_uart_wr");
            6:       bus(1'b0, 1'b1, 1'b1, 32'hC000_0000 | d, d, "rnd_unmapped");
            7:       bus(1'b0, 1'b1, 1'b1, 32'h8000_000C, d, "rnd_unmapped_c");
            default: bus(1'b0, 1'b0, 1'b1, UART, d, "rnd_busy");
         endcase
      end
      for (int i = 0; i < 45; i++) bus(1'b0, 1'b0, 1'b1, UART, 32'd0, "drain");

      rd_chk = 1'b0;
      ln_chk = 1'b0;
      repeat (2) @(posedge clk);
      checks++;
      if (rd_q.size() != 0 || ln_q.size() != 0) begin
         errors++;
         $display("FAIL queues_drained got=%0d/%0d required=0/0", rd_q.size(), ln_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
